multicycle_main_control: RTL and testbench

//   Multicycle RV32I main control FSM. Sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction.

---
 rtl/riscv_ctrl_pkg.sv | 136 +++++++++++++
 rtl/ctrl_mem_timer.sv | 31 +++
 rtl/multicycle_main_control.sv | 131 +++++++++++++
 tb/tb_multicycle_main_control.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, ALUOp codes,
// datapath select codes, FSM state encoding and the per-state control word.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_A_PC    = 2'b00,
        SRC_A_OLDPC = 2'b01,
        SRC_A_RS1   = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        RES_ALUOUT  = 2'b00,
        RES_MEMDATA = 2'b01,
        RES_ALURES  = 2'b10
    } result_src_e;

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADR   = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_ALU_WB    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JAL       = 4'd11,
        S_TRAP      = 4'd12
    } state_e;

    typedef struct packed {
        logic        mem_req;
        logic        mem_write;
        logic        adr_src;
        logic        pc_write;
        logic        branch;
        logic        reg_write;
        alu_src_a_e  alu_src_a;
        alu_src_b_e  alu_src_b;
        alu_op_e     alu_op;
        logic        use_func7;
        result_src_e result_src;
    } ctrl_t;

    // Moore control word for a state; FETCH's ir_write/pc_write strobes are added at the top.
    function automatic ctrl_t state_ctrl(input state_e s, input logic [2:0] func3);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_a  = SRC_A_PC;
                c.alu_src_b  = SRC_B_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALURES;
            end
            S_DECODE: begin
                c.alu_src_a = SRC_A_OLDPC;
                c.alu_src_b = SRC_B_IMM;
            end
            S_MEM_ADR: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_IMM;
            end
            S_MEM_READ: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEM_WB: begin
                c.result_src = RES_MEMDATA;
                c.reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_RS2;
                c.alu_op    = ALUOP_FUNC;
                c.use_func7 = 1'b1;
            end
            S_EXEC_I: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALUOP_FUNC;
                c.use_func7 = (func3 == F3_SRX);
            end
            S_ALU_WB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = SRC_A_RS1;
                c.alu_src_b  = SRC_B_RS2;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRC_A_OLDPC;
                c.alu_src_b  = SRC_B_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_write   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ctrl_mem_timer.sv
// Memory wait watchdog: flags expiry once the request has waited TIMEOUT_CYCLES
// cycles without ready. TIMEOUT_CYCLES = 0 disables it.
module ctrl_mem_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic ready,
    output logic expired
);
    localparam int W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES);
    localparam logic [W-1:0] ONE  = W'(1);

    // Down-counter of remaining wait budget; terminal count is zero.
    logic [W-1:0] remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= LOAD;
        end else if (!enable || ready) begin
            remaining <= LOAD;
        end else if (remaining != '0) begin
            remaining <= remaining - ONE;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && enable && !ready && (remaining == '0);

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle RV32I main control FSM: sequences each instruction and drives the
// datapath selects, ALUOp and the memory req/ready handshake.
//
//   state     | meaning
//   ----------+-------------------------------------------
//   RESET     | all outputs idle, go fetch
//   FETCH     | read instruction at PC, PC+4 into PC
//   DECODE    | branch/jal target into ALUOut
//   MEM_ADR   | rs1+imm effective address
//   MEM_READ  | load request, wait ready
//   MEM_WB    | load data into rd
//   MEM_WRITE | store request, wait ready
//   EXEC_R    | register-register ALU op
//   EXEC_I    | register-immediate ALU op
//   ALU_WB    | ALUOut into rd
//   BRANCH    | compare, conditional PC update
//   JAL       | jump, PC <= target
//   TRAP      | illegal opcode or bus timeout, wait for reset
module multicycle_main_control #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] ALUOp,
    output logic       use_func7,
    output logic [1:0] result_src,
    output logic       illegal,
    output logic       bus_err
);
    import riscv_ctrl_pkg::*;

    state_e state;
    state_e state_next;
    ctrl_t  ctl;
    logic   timer_en;
    logic   timer_expired;
    logic   fetch_ready;

    assign timer_en = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);

    ctrl_mem_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (timer_en),
        .ready  (mem_ready),
        .expired(timer_expired)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_RESET:  state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready)          state_next = S_DECODE;
                else if (timer_expired) state_next = S_TRAP;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
                    OP_R:              state_next = S_EXEC_R;
                    OP_I:              state_next = S_EXEC_I;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEM_ADR: state_next = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (mem_ready)          state_next = S_MEM_WB;
                else if (timer_expired) state_next = S_TRAP;
            end
            S_MEM_WB: state_next = S_FETCH;
            S_MEM_WRITE: begin
                if (mem_ready)          state_next = S_FETCH;
                else if (timer_expired) state_next = S_TRAP;
            end
            S_EXEC_R: state_next = S_ALU_WB;
            S_EXEC_I: state_next = S_ALU_WB;
            S_ALU_WB: state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_JAL:    state_next = S_ALU_WB;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_RESET;
        endcase
    end

    // Control word is registered alongside the state so outputs come straight off flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RESET;
            ctl     <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state   <= state_next;
            ctl     <= state_ctrl(state_next, func3);
            illegal <= illegal | ((state == S_DECODE) && (state_next == S_TRAP));
            bus_err <= bus_err | timer_expired;
        end
    end

    assign fetch_ready = (state == S_FETCH) && mem_ready;

    assign mem_req    = ctl.mem_req;
    assign mem_write  = ctl.mem_write;
    assign adr_src    = ctl.adr_src;
    assign ir_write   = fetch_ready;
    assign pc_write   = ctl.pc_write | fetch_ready;
    assign branch     = ctl.branch;
    assign reg_write  = ctl.reg_write;
    assign alu_src_a  = ctl.alu_src_a;
    assign alu_src_b  = ctl.alu_src_b;
    assign ALUOp      = ctl.alu_op;
    assign use_func7  = ctl.use_func7;
    assign result_src = ctl.result_src;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed, table-driven bench for multicycle_main_control (TIMEOUT_CYCLES = 4).
module tb_multicycle_main_control;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       reg_write;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic       f7;
        logic [1:0] res;
        logic       illegal;
        logic       bus_err;
    } outs_t;

    typedef struct {
        string      tag;
        logic [6:0] opcode;
        logic [2:0] func3;
        logic       ready;
        outs_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, branch, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       use_func7, illegal, bus_err;

    outs_t act;
    int    errors = 0;
    int    checks = 0;
    vec_t  vecs[$];

    always #5 clk = ~clk;

    multicycle_main_control #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .func3     (func3),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_write (mem_write),
        .adr_src   (adr_src),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .branch    (branch),
        .reg_write (reg_write),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .ALUOp     (alu_op),
        .use_func7 (use_func7),
        .result_src(result_src),
        .illegal   (illegal),
        .bus_err   (bus_err)
    );

    always_comb act = {mem_req, mem_write, adr_src, ir_write, pc_write, branch, reg_write,
                       alu_src_a, alu_src_b, alu_op, use_func7, result_src, illegal, bus_err};

    // Expected output words, hand-derived per state:
    //                 req w adr ir pc br rw a     b     op    f7 res   ill be
    localparam outs_t E_ZERO      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0};
    localparam outs_t E_FETCH_W   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0,2'b10,1'b0,1'b0};
    localparam outs_t E_FETCH_R   = {1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0,2'b10,1'b0,1'b0};
    localparam outs_t E_DECODE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,1'b0,2'b00,1'b0,1'b0};
    localparam outs_t E_MEM_ADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,1'b0,2'b00,1'b0,1'b0};
    localparam outs_t E_MEM_RD    = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0};
    localparam outs_t E_MEM_WB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,1'b0,2'b01,1'b0,1'b0};
    localparam outs_t E_MEM_WR    = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0};
    localparam outs_t E_EXEC_R    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,1'b1,2'b00,1'b0,1'b0};
    localparam outs_t E_EXEC_I_F7 = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b10,1'b1,2'b00,1'b0,1'b0};
    localparam outs_t E_EXEC_I    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b10,1'b0,2'b00,1'b0,1'b0};
    localparam outs_t E_ALU_WB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0};
    localparam outs_t E_BRANCH    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b01,1'b0,2'b00,1'b0,1'b0};
    localparam outs_t E_JAL       = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b01,2'b10,2'b00,1'b0,2'b00,1'b0,1'b0};
    localparam outs_t E_TRAP_ILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0};
    localparam outs_t E_TRAP_BUS  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,2'b00,1'b0,1'b1};

    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011;
    localparam logic [6:0] RI = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;

    task automatic add(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic rdy, input outs_t exp);
        vec_t v;
        v.tag = tag; v.opcode = op; v.func3 = f3; v.ready = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string tag, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_check(input string tag, input logic [6:0] op, input logic rdy,
                               input outs_t exp);
        opcode = op; mem_ready = rdy;
        #1;
        check(tag, exp);
        step();
    endtask

    initial begin
        rst_n = 1'b0; opcode = RR; func3 = 3'b000; mem_ready = 1'b0;

        // R-type
        add("r_reset",   RR, 3'b000, 1'b1, E_ZERO);
        add("r_fetch",   RR, 3'b000, 1'b1, E_FETCH_R);
        add("r_decode",  RR, 3'b000, 1'b1, E_DECODE);
        add("r_exec",    RR, 3'b000, 1'b1, E_EXEC_R);
        add("r_wb",      RR, 3'b000, 1'b1, E_ALU_WB);
        // load with 3 wait cycles in MEM_READ
        add("ld_fetch",  LD, 3'b010, 1'b1, E_FETCH_R);
        add("ld_decode", LD, 3'b010, 1'b0, E_DECODE);
        add("ld_adr",    LD, 3'b010, 1'b1, E_MEM_ADR);
        add("ld_wait0",  LD, 3'b010, 1'b0, E_MEM_RD);
        add("ld_wait1",  LD, 3'b010, 1'b0, E_MEM_RD);
        add("ld_wait2",  LD, 3'b010, 1'b0, E_MEM_RD);
        add("ld_rdy",    LD, 3'b010, 1'b1, E_MEM_RD);
        add("ld_wb",     LD, 3'b010, 1'b1, E_MEM_WB);
        // store, one fetch wait cycle
        add("st_fwait",  ST, 3'b010, 1'b0, E_FETCH_W);
        add("st_fetch",  ST, 3'b010, 1'b1, E_FETCH_R);
        add("st_decode", ST, 3'b010, 1'b1, E_DECODE);
        add("st_adr",    ST, 3'b010, 1'b0, E_MEM_ADR);
        add("st_write",  ST, 3'b010, 1'b1, E_MEM_WR);
        // branch
        add("br_fetch",  BR, 3'b000, 1'b1, E_FETCH_R);
        add("br_decode", BR, 3'b000, 1'b1, E_DECODE);
        add("br_exec",   BR, 3'b000, 1'b1, E_BRANCH);
        // srai/srli: func7 visible
        add("sr_fetch",  RI, 3'b101, 1'b1, E_FETCH_R);
        add("sr_decode", RI, 3'b101, 1'b1, E_DECODE);
        add("sr_exec",   RI, 3'b101, 1'b1, E_EXEC_I_F7);
        add("sr_wb",     RI, 3'b101, 1'b1, E_ALU_WB);
        // addi: func7 forced to 0
        add("ai_fetch",  RI, 3'b000, 1'b1, E_FETCH_R);
        add("ai_decode", RI, 3'b000, 1'b1, E_DECODE);
        add("ai_exec",   RI, 3'b000, 1'b1, E_EXEC_I);
        add("ai_wb",     RI, 3'b000, 1'b1, E_ALU_WB);
        // jal
        add("j_fetch",   JL, 3'b000, 1'b1, E_FETCH_R);
        add("j_decode",  JL, 3'b000, 1'b1, E_DECODE);
        add("j_jal",     JL, 3'b000, 1'b1, E_JAL);
        add("j_wb",      JL, 3'b000, 1'b1, E_ALU_WB);
        // illegal opcode, sticky in TRAP
        add("il_fetch",  BAD, 3'b000, 1'b1, E_FETCH_R);
        add("il_decode", BAD, 3'b000, 1'b1, E_DECODE);
        add("il_trap0",  BAD, 3'b000, 1'b1, E_TRAP_ILL);
        add("il_trap1",  RR,  3'b000, 1'b1, E_TRAP_ILL);
        add("il_trap2",  RR,  3'b000, 1'b0, E_TRAP_ILL);

        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", E_ZERO);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            opcode = vecs[i].opcode; func3 = vecs[i].func3; mem_ready = vecs[i].ready;
            #1;
            check(vecs[i].tag, vecs[i].exp);
            step();
        end

        // reset out of TRAP clears illegal immediately
        rst_n = 1'b0;
        #1;
        check("trap_rst", E_ZERO);
        step();
        rst_n = 1'b1;
        func3 = 3'b000;

        // timeout in FETCH: 4 counted waits, expiry on the 5th waiting cycle
        drive_check("to_reset", RR, 1'b0, E_ZERO);
        for (int k = 0; k < 5; k++) drive_check($sformatf("to_wait%0d", k), RR, 1'b0, E_FETCH_W);
        drive_check("to_trap0", RR, 1'b1, E_TRAP_BUS);
        drive_check("to_trap1", RR, 1'b0, E_TRAP_BUS);

        rst_n = 1'b0;
        #1;
        check("to_rst", E_ZERO);
        step();
        rst_n = 1'b1;

        // ready arrives in the expiry cycle: ready wins
        drive_check("rw_reset", RR, 1'b0, E_ZERO);
        for (int k = 0; k < 4; k++) drive_check($sformatf("rw_wait%0d", k), RR, 1'b0, E_FETCH_W);
        drive_check("rw_ready", RR, 1'b1, E_FETCH_R);
        drive_check("rw_decode", RR, 1'b0, E_DECODE);
        drive_check("rw_exec", RR, 1'b0, E_EXEC_R);
        drive_check("rw_wb", RR, 1'b0, E_ALU_WB);

        // reset mid-wait: outputs drop at once, timer starts fresh afterwards
        drive_check("mw_wait0", RR, 1'b0, E_FETCH_W);
        drive_check("mw_wait1", RR, 1'b0, E_FETCH_W);
        #2;
        rst_n = 1'b0;
        #1;
        check("mw_rst", E_ZERO);
        step();
        rst_n = 1'b1;
        drive_check("mw_reset", RR, 1'b0, E_ZERO);
        for (int k = 0; k < 4; k++) drive_check($sformatf("mw_fwait%0d", k), RR, 1'b0, E_FETCH_W);
        drive_check("mw_ready", RR, 1'b1, E_FETCH_R);
        drive_check("mw_decode", RR, 1'b0, E_DECODE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
